// File: rtl/tl_get_issuer_if.sv
// Bundles the refill request, TileLink A and D channel signals seen by tl_get_issuer.
// The master modport is the issuer's view; slave is the core/queue/D-monitor side.
interface tl_get_issuer_if #(
    parameter int unsigned ADDR_W = 33
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_address;
    logic [2:0]        req_param;

    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [2:0]        a_source;
    logic [ADDR_W-1:0] a_address;

    logic              d_valid;
    logic [2:0]        d_source;
    logic              d_last;

    modport master (
        input  req_valid, req_address, req_param, a_ready, d_valid, d_source, d_last,
        output req_ready, a_valid, a_opcode, a_param, a_source, a_address
    );

    modport slave (
        output req_valid, req_address, req_param, a_ready, d_valid, d_source, d_last,
        input  req_ready, a_valid, a_opcode, a_param, a_source, a_address
    );
endinterface

// File: rtl/tl_get_issuer.sv
// Issues line-aligned TileLink Get requests, owning an 8-entry source-ID pool with
// per-source line tracking so a line is never fetched twice concurrently.
module tl_get_issuer #(
    parameter int unsigned ADDR_W   = 33,
    parameter int unsigned LINE_OFF = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_get_issuer_if.master        bus,
    output logic [7:0]             inflight,
    output logic [3:0]             outstanding,
    output logic                   idle,
    output logic                   err_spurious
);
    localparam int unsigned LineW = ADDR_W - LINE_OFF;
    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((64'd1 << LINE_OFF) - 64'd1);

    logic              a_valid_q, a_valid_d;
    logic [2:0]        a_param_q, a_param_d;
    logic [2:0]        a_source_q, a_source_d;
    logic [ADDR_W-1:0] a_address_q, a_address_d;
    logic [7:0]        inflight_q, inflight_d;
    logic [3:0]        outstanding_q, outstanding_d;
    logic              err_q, err_d;
    logic [LineW-1:0]  line_q [8];

    logic [LineW-1:0]  req_line;
    logic [ADDR_W-1:0] aligned_addr;
    logic              conflict;
    logic [2:0]        alloc_idx;
    logic              can_load;
    logic              has_free;
    logic              ready;
    logic              accept;
    logic              d_end;
    logic              retire;

    assign req_line     = bus.req_address[ADDR_W-1:LINE_OFF];
    assign aligned_addr = bus.req_address & ~OffMask;

    // A retiring source still blocks its line this cycle: only the registered vector is used.
    always_comb begin
        conflict = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (inflight_q[k] && (line_q[k] == req_line)) begin
                conflict = 1'b1;
            end
        end
    end

    always_comb begin
        alloc_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (!inflight_q[k]) begin
                alloc_idx = 3'(k);
            end
        end
    end

    assign can_load = !a_valid_q || bus.a_ready;
    assign has_free = ~&inflight_q;
    assign ready    = can_load && has_free && !conflict;
    assign accept   = bus.req_valid && ready;
    assign d_end    = bus.d_valid && bus.d_last;
    assign retire   = d_end && inflight_q[bus.d_source];

    always_comb begin
        inflight_d    = inflight_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        a_valid_d     = a_valid_q;
        a_param_d     = a_param_q;
        a_source_d    = a_source_q;
        a_address_d   = a_address_q;

        if (retire) begin
            inflight_d[bus.d_source] = 1'b0;
        end
        if (d_end && !inflight_q[bus.d_source]) begin
            err_d = 1'b1;
        end
        // alloc_idx is free in the pre-edge vector, so it never collides with the retiring bit.
        if (accept) begin
            inflight_d[alloc_idx] = 1'b1;
        end

        if (accept && !retire) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && retire) begin
            outstanding_d = outstanding_q - 4'd1;
        end

        if (accept) begin
            a_valid_d   = 1'b1;
            a_param_d   = bus.req_param;
            a_source_d  = alloc_idx;
            a_address_d = aligned_addr;
        end else if (a_valid_q && bus.a_ready) begin
            a_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_valid_q     <= 1'b0;
            a_param_q     <= 3'd0;
            a_source_q    <= 3'd0;
            a_address_q   <= '0;
            inflight_q    <= 8'd0;
            outstanding_q <= 4'd0;
            err_q         <= 1'b0;
        end else begin
            a_valid_q     <= a_valid_d;
            a_param_q     <= a_param_d;
            a_source_q    <= a_source_d;
            a_address_q   <= a_address_d;
            inflight_q    <= inflight_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Line tags are only meaningful while the matching inflight bit is set, so no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            line_q[alloc_idx] <= req_line;
        end
    end

    assign bus.req_ready = ready;
    assign bus.a_valid   = a_valid_q;
    assign bus.a_opcode  = 3'd4;
    assign bus.a_param   = a_param_q;
    assign bus.a_source  = a_source_q;
    assign bus.a_address = a_address_q;

    assign inflight     = inflight_q;
    assign outstanding  = outstanding_q;
    assign idle         = (inflight_q == 8'd0) && !a_valid_q;
    assign err_spurious = err_q;
endmodule
